program_loader: RTL and testbench

//   Byte-stream program loader that sits directly upstream of the 1K x 18 PicoBlaze program BRAM.

---
 rtl/program_loader_pkg.sv | 30 +++
 rtl/program_loader_watchdog.sv | 39 +++
 rtl/program_loader.sv | 205 ++++++++++++++++++++
 tb/tb_program_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the PicoBlaze program loader.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
package program_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StB0,
    StB1,
    StB2,
    StCsum,
    StError
  } state_t;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'h5A;
  localparam int unsigned MAX_WORDS         = 1024;
  localparam int unsigned ADDR_W            = 10;
  localparam int unsigned INSTR_W           = 18;
  // B0 carries only the top instruction bits; the rest of that byte must be zero.
  localparam int unsigned HI_W              = 2;
  localparam logic [3:0]  WE_ALL            = 4'b1111;

  function automatic logic [INSTR_W-1:0] pack_word(input logic [HI_W-1:0] hi,
                                                   input logic [7:0]      mid,
                                                   input logic [7:0]      lo);
    return {hi, mid, lo};
  endfunction

endpackage

// File: rtl/program_loader_watchdog.sv
// Inter-byte timeout counter: expires when TIMEOUT_CYCLES cycles pass without a kick.
module loader_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Kick wins, so a byte arriving on the final cycle still counts as in time.
  assign expired = enable && !kick && (count_q == LAST);

  // Next count: cleared on kick or when disabled, otherwise count up to the limit.
  always_comb begin
    count_d = count_q;
    if (!enable || kick) begin
      count_d = '0;
    end else if (!expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader for the 1K x 18 PicoBlaze program BRAM.
// Packs 3 received bytes per instruction, writes them to BRAM and holds the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic [ADDR_W-1:0]  cpu_address,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [INSTR_W-1:0] mem_data,
  output logic [3:0]         mem_we,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               load_error
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [HI_W-1:0]     b0_q, b0_d;
  logic [7:0]          b1_q, b1_d;
  logic [INSTR_W-1:0]  data_q, data_d;
  logic                wr_pend_q, wr_pend_d;
  logic                fin_pend_q, fin_pend_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                load_done_q, load_done_d;
  logic                load_error_q, load_error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic [ADDR_W:0] n_rx;
  logic            last_word;
  logic            wd_expired;

  assign n_rx      = {len_hi_q[2:0], rx_data};
  assign last_word = ({1'b0, index_q} == (n_q - 1'b1));

  loader_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q != StIdle && state_q != StError),
    .kick   (rx_valid),
    .expired(wd_expired)
  );

  // Next-state: one byte per rx_valid, write/finish bookkeeping, watchdog abort.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    n_d          = n_q;
    len_hi_d     = len_hi_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    data_d       = data_q;
    wr_pend_d    = 1'b0;
    fin_pend_d   = 1'b0;
    cpu_reset_d  = cpu_reset_q;
    load_done_d  = 1'b0;
    load_error_d = load_error_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    // Index advances once the write cycle is on the bus.
    if (wr_pend_q) index_d = index_q + 1'b1;
    // Release the CPU only after the final write has been issued.
    if (fin_pend_q) begin
      load_done_d = 1'b1;
      cpu_reset_d = 1'b0;
    end

    if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
      if (state_q inside {StLenHi, StLenLo, StB0, StB1, StB2}) csum_d = csum_q ^ rx_data;
`endif
      unique case (state_q)
        StIdle, StError: begin
          if (rx_data == SYNC_BYTE) begin
            state_d      = StLenHi;
            index_d      = '0;
            cpu_reset_d  = 1'b1;
            load_error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_d       = '0;
`endif
          end
        end
        StLenHi: begin
          len_hi_d = rx_data;
          state_d  = StLenLo;
        end
        StLenLo: begin
          if (len_hi_q[7:3] != '0 || n_rx == '0 || n_rx > (ADDR_W + 1)'(MAX_WORDS)) begin
            state_d      = StError;
            load_error_d = 1'b1;
          end else begin
            n_d     = n_rx;
            state_d = StB0;
          end
        end
        StB0: begin
          if (rx_data[7:HI_W] != '0) begin
            state_d      = StError;
            load_error_d = 1'b1;
          end else begin
            b0_d    = rx_data[HI_W-1:0];
            state_d = StB1;
          end
        end
        StB1: begin
          b1_d    = rx_data;
          state_d = StB2;
        end
        StB2: begin
          data_d    = pack_word(b0_q, b1_q, rx_data);
          wr_pend_d = 1'b1;
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_d    = StCsum;
`else
            state_d    = StIdle;
            fin_pend_d = 1'b1;
`endif
          end else begin
            state_d = StB0;
          end
        end
        StCsum: begin
`ifdef LOADER_CHECKSUM_EN
          if (rx_data == csum_q) begin
            state_d     = StIdle;
            load_done_d = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d      = StError;
            load_error_d = 1'b1;
          end
`else
          state_d = StIdle;
`endif
        end
        default: state_d = StIdle;
      endcase
    end else if (wd_expired) begin
      state_d      = StError;
      load_error_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      index_q      <= '0;
      n_q          <= '0;
      len_hi_q     <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      data_q       <= '0;
      wr_pend_q    <= 1'b0;
      fin_pend_q   <= 1'b0;
      cpu_reset_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      n_q          <= n_d;
      len_hi_q     <= len_hi_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      data_q       <= data_d;
      wr_pend_q    <= wr_pend_d;
      fin_pend_q   <= fin_pend_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // CPU fetch address passes through only when no load or write is in flight.
  assign mem_address = (state_q == StIdle && !wr_pend_q) ? cpu_address : index_q;
  assign mem_data    = data_q;
  assign mem_we      = wr_pend_q ? WE_ALL : 4'b0000;
  assign cpu_reset   = cpu_reset_q;
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: scoreboard of expected BRAM writes.
// Honours LOADER_CHECKSUM_EN when the design is built with it.
module tb_program_loader;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [9:0]  cpu_address;
  logic [9:0]  mem_address;
  logic [17:0] mem_data;
  logic [3:0]  mem_we;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          done_cnt  = 0;
  int          exp_done  = 0;
  logic [27:0] exp_q[$];
  logic [27:0] e_mon;
  logic [17:0] words[1024];

  program_loader #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cpu_address(cpu_address),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends a full frame of words[0..n-1]; pushes expected writes as each B2 goes out.
  task automatic send_frame(input logic [7:0] lh, input logic [7:0] ll, input int n,
                            input bit bad_csum);
    logic [7:0]  cs;
    logic [17:0] w;
    send_byte(8'h5A);
    check("cpu_reset_on_sync", 32'(cpu_reset), 32'd1);
    cs = lh ^ ll;
    send_byte(lh);
    send_byte(ll);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      send_byte({6'b0, w[17:16]});
      send_byte(w[15:8]);
      send_byte(w[7:0]);
      exp_q.push_back({i[9:0], w});
      cs = cs ^ {6'b0, w[17:16]} ^ w[15:8] ^ w[7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_csum ? ~cs : cs);
`else
    if (bad_csum) cs = ~cs;
`endif
  endtask

  // Scoreboard side: every write is popped and compared; done pulses are counted.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we != 4'h0) begin
        check("we_value", 32'(mem_we), 32'hF);
        check("we_cpu_reset", 32'(cpu_reset), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_we", 32'(mem_we), 32'h0);
        end else begin
          e_mon = exp_q.pop_front();
          check("wr_addr", 32'(mem_address), 32'(e_mon[27:18]));
          check("wr_data", 32'(mem_data), 32'(e_mon[17:0]));
        end
      end
      if (load_done) begin
        done_cnt++;
        check("done_cpu_reset", 32'(cpu_reset), 32'd0);
      end
    end
  end

  task automatic expect_success(input string tag);
    exp_done++;
    idle(4);
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_error"}, 32'(load_error), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic expect_error(input string tag);
    idle(3);
    check({tag, "_error"}, 32'(load_error), 32'd1);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    cpu_address = 10'h155;
    idle(2);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_data", 32'(mem_data), 32'h0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    reset = 1'b0;
    idle(2);

    // Idle pass-through of the fetch address.
    check("idle_addr", 32'(mem_address), 32'h155);
    check("idle_we", 32'(mem_we), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cpu_address = 10'($urandom);
      #1;
      check("idle_addr_rnd", 32'(mem_address), 32'(cpu_address));
    end

    // Basic two-word frame.
    words[0] = 18'h3FF0F;
    words[1] = 18'h01234;
    send_frame(8'h00, 8'h02, 2, 1'b0);
    expect_success("basic");

    // N=1025, N=0 and non-zero LEN_HI top bits are all rejected.
    send_byte(8'h5A); send_byte(8'h04); send_byte(8'h01);
    expect_error("len1025");
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h00);
    expect_error("len0");
    send_byte(8'h5A); send_byte(8'h08); send_byte(8'h01);
    expect_error("lenhi_bits");

    // Recovery; SYNC value inside the payload is data.
    words[0] = 18'h05A5A;
    for (int i = 1; i < 5; i++) words[i] = 18'($urandom);
    send_frame(8'h00, 8'h05, 5, 1'b0);
    expect_success("recover");

    // Bad B0 in word 0: no write, trailing bytes ignored.
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h01); send_byte(8'h04);
    send_byte(8'h12); send_byte(8'h34);
    expect_error("bad_b0");

    // Gap of TO-1 idle cycles inside a frame does not abort.
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h23);
    idle(TO - 1);
    check("gap_no_abort", 32'(load_error), 32'd0);
    send_byte(8'h45);
    exp_q.push_back({10'd0, 18'h12345});
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00 ^ 8'h01 ^ 8'h01 ^ 8'h23 ^ 8'h45);
`endif
    expect_success("gap");

    // Stalling after two payload bytes times out after exactly TO cycles.
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h23);
    idle(TO - 1);
    check("timeout_before", 32'(load_error), 32'd0);
    idle(1);
    check("timeout_at", 32'(load_error), 32'd1);
    check("timeout_cpu_reset", 32'(cpu_reset), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: words already written stay written, load errors out.
    words[0] = 18'h3FF0F;
    words[1] = 18'h01234;
    send_frame(8'h00, 8'h02, 2, 1'b1);
    expect_error("bad_csum");
`endif

    // Largest legal image: 1024 words, last write at index 1023.
    for (int i = 0; i < 1024; i++) words[i] = 18'($urandom);
    send_frame(8'h04, 8'h00, 1024, 1'b0);
    expect_success("max_len");

    // Asynchronous reset mid-frame releases the CPU immediately.
    words[0] = 18'h10203;
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    exp_q.push_back({10'd0, 18'h10203});
    send_byte(8'h00);
    cpu_address = 10'h2AA;
    reset = 1'b1;
    #1;
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("midrst_error", 32'(load_error), 32'd0);
    check("midrst_addr", 32'(mem_address), 32'h2AA);
    check("midrst_we", 32'(mem_we), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    send_byte(8'h12); send_byte(8'h34);
    idle(3);
    check("post_rst_done", 32'(done_cnt), 32'(exp_done));
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);
    check("post_rst_cpu_reset", 32'(cpu_reset), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
